// File: rtl/weight_writer_layer1_if.sv
// ---------------------------------------------------------------------------
// weight_writer_layer1_if: BRAM port bundle shared by the weight writer/loaders
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface weight_writer_layer1_if #(
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 15
);
  logic                  bram_en;
  logic                  bram_ren;
  logic                  bram_wen;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [W-1:0]          bram_din;
  logic [W-1:0]          bram_dout;

  modport master (
    output bram_en, bram_ren, bram_wen, bram_addr, bram_din,
    input  bram_dout
  );

  modport slave (
    input  bram_en, bram_ren, bram_wen, bram_addr, bram_din,
    output bram_dout
  );
endinterface

`default_nettype wire

// File: rtl/weight_writer_layer1.sv
// ---------------------------------------------------------------------------
// weight_writer_layer1: serialise packed layer-1 weights into BRAM, optional readback check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module weight_writer_layer1 #(
  parameter int IN_SIZE       = 256,
  parameter int OUT_SIZE      = 8,
  parameter int W             = 8,
  parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE,
  parameter int ADDR_WIDTH    = 15,
  parameter int BASE_ADDR     = 12288,
  parameter int READ_LATENCY  = 2,
  parameter int VERIFY_EN     = 1
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       start,
  input  wire logic [TOTAL_WEIGHTS*W-1:0] data_in,
  weight_writer_layer1_if.master          bram,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_WIDTH:0]             mismatch_count,
  output logic                            error
);

  localparam logic [ADDR_WIDTH:0] T_CNT  = (ADDR_WIDTH+1)'(TOTAL_WEIGHTS);
  localparam logic [ADDR_WIDTH:0] T_LAST = (ADDR_WIDTH+1)'(TOTAL_WEIGHTS - 1);
  // Every read-pipeline stage except the one being compared this cycle
  localparam logic [READ_LATENCY-1:0] EARLY_MASK =
    READ_LATENCY'((64'd1 << (READ_LATENCY - 1)) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_VERIFY = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam state_t S_AFTER_WRITE = (VERIFY_EN != 0) ? S_VERIFY : S_DONE;

  if (BASE_ADDR + TOTAL_WEIGHTS - 1 >= (1 << ADDR_WIDTH)) begin : g_addr_range_bad
    $error("weight_writer_layer1: BASE_ADDR+TOTAL_WEIGHTS-1 exceeds the BRAM address space");
  end
  if (READ_LATENCY < 1) begin : g_latency_bad
    $error("weight_writer_layer1: READ_LATENCY must be at least 1");
  end

  state_t                       state;
  logic [TOTAL_WEIGHTS*W-1:0]   shadow;
  logic [ADDR_WIDTH:0]          wr_ptr;
  logic [ADDR_WIDTH:0]          rd_ptr;
  logic [READ_LATENCY-1:0]      vld_sr;
  logic [ADDR_WIDTH:0]          idx_sr [READ_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      shadow         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      vld_sr         <= '0;
      for (int i = 0; i < READ_LATENCY; i++) idx_sr[i] <= '0;
      bram.bram_en   <= 1'b0;
      bram.bram_ren  <= 1'b0;
      bram.bram_wen  <= 1'b0;
      bram.bram_addr <= '0;
      bram.bram_din  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mismatch_count <= '0;
      error          <= 1'b0;
    end else begin
      // Outstanding-read tracker advances every cycle; VERIFY refills stage 0
      vld_sr[0] <= 1'b0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end

      if (vld_sr[READ_LATENCY-1] &&
          (bram.bram_dout != shadow[int'(idx_sr[READ_LATENCY-1])*W +: W]) &&
          (mismatch_count != T_CNT)) begin
        mismatch_count <= mismatch_count + 1'b1;
        error          <= 1'b1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          bram.bram_en  <= 1'b0;
          bram.bram_ren <= 1'b0;
          bram.bram_wen <= 1'b0;
          if (state == S_DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
          // busy is still high on the first DONE cycle, so start is ignored there
          if (start && !busy) begin
            shadow         <= data_in;
            done           <= 1'b0;
            busy           <= 1'b1;
            mismatch_count <= '0;
            error          <= 1'b0;
            vld_sr         <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= (ADDR_WIDTH+1)'(1);
            bram.bram_en   <= 1'b1;
            bram.bram_wen  <= 1'b1;
            bram.bram_ren  <= 1'b0;
            bram.bram_addr <= ADDR_WIDTH'(BASE_ADDR);
            bram.bram_din  <= data_in[W-1:0];
            state          <= (TOTAL_WEIGHTS == 1) ? S_AFTER_WRITE : S_WRITE;
          end
        end

        S_WRITE: begin
          bram.bram_en   <= 1'b1;
          bram.bram_wen  <= 1'b1;
          bram.bram_ren  <= 1'b0;
          bram.bram_addr <= ADDR_WIDTH'(BASE_ADDR + int'(wr_ptr));
          bram.bram_din  <= shadow[int'(wr_ptr)*W +: W];
          wr_ptr         <= wr_ptr + 1'b1;
          if (wr_ptr == T_LAST) state <= S_AFTER_WRITE;
        end

        S_VERIFY: begin
          bram.bram_en   <= 1'b1;
          bram.bram_wen  <= 1'b0;
          bram.bram_ren  <= 1'b1;
          bram.bram_addr <= ADDR_WIDTH'(BASE_ADDR + int'(rd_ptr));
          vld_sr[0]      <= 1'b1;
          idx_sr[0]      <= rd_ptr;
          rd_ptr         <= rd_ptr + 1'b1;
          if (rd_ptr == T_LAST) state <= S_DRAIN;
        end

        S_DRAIN: begin
          bram.bram_en  <= 1'b1;
          bram.bram_wen <= 1'b0;
          bram.bram_ren <= 1'b0;
          if ((vld_sr & EARLY_MASK) == '0) state <= S_DONE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_weight_writer_layer1.sv
// ---------------------------------------------------------------------------
// tb_weight_writer_layer1: directed vectors against a small behavioural BRAM model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_weight_writer_layer1;
  localparam int T    = 8;
  localparam int W    = 8;
  localparam int AW   = 15;
  localparam int BASE = 12288;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start_v, start_n;
  logic [T*W-1:0]    data_v, data_n;
  logic              busy_v, done_v, err_v, busy_n, done_n, err_n;
  logic [AW:0]       mm_v, mm_n;

  weight_writer_layer1_if #(.W(W), .ADDR_WIDTH(AW)) bus_v ();
  weight_writer_layer1_if #(.W(W), .ADDR_WIDTH(AW)) bus_n ();

  weight_writer_layer1 #(.IN_SIZE(4), .OUT_SIZE(2), .W(W), .ADDR_WIDTH(AW),
                         .BASE_ADDR(BASE), .READ_LATENCY(2), .VERIFY_EN(1)) dut_v (
    .clk(clk), .rst(rst), .start(start_v), .data_in(data_v), .bram(bus_v),
    .busy(busy_v), .done(done_v), .mismatch_count(mm_v), .error(err_v));

  weight_writer_layer1 #(.IN_SIZE(4), .OUT_SIZE(2), .W(W), .ADDR_WIDTH(AW),
                         .BASE_ADDR(BASE), .READ_LATENCY(2), .VERIFY_EN(0)) dut_n (
    .clk(clk), .rst(rst), .start(start_n), .data_in(data_n), .bram(bus_n),
    .busy(busy_n), .done(done_n), .mismatch_count(mm_n), .error(err_n));

  // BRAM models: read data appears L=2 edges after the edge following the address
  logic [7:0] mem_v [0:32767];
  logic [7:0] mem_n [0:32767];
  logic [7:0] pipe_v, pipe_n;
  int wen_v = 0, ren_v = 0, bad_v = 0, wen_n = 0, ren_n = 0;
  int corrupt_mode = 0;

  assign bus_v.bram_dout = pipe_v;
  assign bus_n.bram_dout = pipe_n;

  always @(posedge clk) begin
    if (bus_v.bram_en && bus_v.bram_wen) begin
      mem_v[bus_v.bram_addr] <= bus_v.bram_din;
      wen_v <= wen_v + 1;
      if (bus_v.bram_addr < 15'(BASE) || bus_v.bram_addr > 15'(BASE + T - 1)) bad_v <= bad_v + 1;
    end
    if (bus_v.bram_en && bus_v.bram_ren) begin
      ren_v <= ren_v + 1;
      if (bus_v.bram_addr < 15'(BASE) || bus_v.bram_addr > 15'(BASE + T - 1)) bad_v <= bad_v + 1;
      if (corrupt_mode == 2)                                      pipe_v <= ~mem_v[bus_v.bram_addr];
      else if (corrupt_mode == 1 && bus_v.bram_addr == 15'(BASE + 3)) pipe_v <= 8'hFF;
      else                                                        pipe_v <= mem_v[bus_v.bram_addr];
    end
  end

  always @(posedge clk) begin
    if (bus_n.bram_en && bus_n.bram_wen) begin
      mem_n[bus_n.bram_addr] <= bus_n.bram_din;
      wen_n <= wen_n + 1;
    end
    if (bus_n.bram_en && bus_n.bram_ren) begin
      ren_n  <= ren_n + 1;
      pipe_n <= mem_n[bus_n.bram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [T*W-1:0] pack(input logic [7:0] base);
    logic [T*W-1:0] d;
    for (int k = 0; k < T; k++) d[k*W +: W] = base + 8'(k);
    return d;
  endfunction

  function automatic int bad_words_v(input logic [7:0] base, input int first, input int last);
    int bad = 0;
    for (int k = first; k <= last; k++)
      if (mem_v[15'(BASE + k)] !== base + 8'(k)) bad++;
    return bad;
  endfunction

  // Start dut_v at edge 0 and return the first edge at which done is seen high
  task automatic run_v(input logic [7:0] base, input bit noisy, output int de);
    @(negedge clk);
    data_v  = pack(base);
    start_v = 1'b1;
    @(posedge clk); #1;
    chk("busy_at_start", busy_v, 1);
    chk("done_cleared", done_v, 0);
    chk("mm_restart", mm_v, 0);
    de = -1;
    for (int e = 1; e < 60; e++) begin
      @(negedge clk);
      start_v = noisy && (e == 3 || e == 12);
      if (noisy) data_v = {T{8'hAA}};
      @(posedge clk); #1;
      if (done_v) begin
        de = e;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] base;
    int         corrupt;
    int         exp_mm;
    logic       exp_err;
    int         exp_done;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int de, w0, r0;
    vecs[0] = '{8'h10, 0, 0, 1'b0, 18};
    vecs[1] = '{8'h10, 1, 1, 1'b1, 18};
    vecs[2] = '{8'h20, 0, 0, 1'b0, 18};
    vecs[3] = '{8'h30, 2, 8, 1'b1, 18};

    rst = 1'b1; start_v = 1'b0; start_n = 1'b0; data_v = '0; data_n = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", bus_v.bram_en, 0);
    chk("rst_ren", bus_v.bram_ren, 0);
    chk("rst_wen", bus_v.bram_wen, 0);
    chk("rst_addr", bus_v.bram_addr, 0);
    chk("rst_din", bus_v.bram_din, 0);
    chk("rst_busy", busy_v, 0);
    chk("rst_done", done_v, 0);
    chk("rst_mm", mm_v, 0);
    chk("rst_err", err_v, 0);
    rst = 1'b0;

    // Back-to-back runs from the vector table, each restarting from DONE
    foreach (vecs[i]) begin
      w0 = wen_v; r0 = ren_v;
      corrupt_mode = vecs[i].corrupt;
      run_v(vecs[i].base, 1'b0, de);
      chk($sformatf("v%0d_done_edge", i), de, vecs[i].exp_done);
      chk($sformatf("v%0d_mm", i), mm_v, vecs[i].exp_mm);
      chk($sformatf("v%0d_err", i), err_v, vecs[i].exp_err);
      chk($sformatf("v%0d_busy", i), busy_v, 0);
      chk($sformatf("v%0d_wen_cnt", i), wen_v - w0, T);
      chk($sformatf("v%0d_ren_cnt", i), ren_v - r0, T);
      chk($sformatf("v%0d_mem", i), bad_words_v(vecs[i].base, 0, T-1), 0);
      chk($sformatf("v%0d_bad_addr", i), bad_v, 0);
    end
    corrupt_mode = 0;

    // data_in changes after start and stray start pulses in WRITE and VERIFY
    w0 = wen_v; r0 = ren_v;
    run_v(8'h10, 1'b1, de);
    chk("noisy_done_edge", de, 18);
    chk("noisy_wen_cnt", wen_v - w0, T);
    chk("noisy_ren_cnt", ren_v - r0, T);
    chk("noisy_mem", bad_words_v(8'h10, 0, T-1), 0);
    chk("noisy_mm", mm_v, 0);
    @(negedge clk);
    chk("done_held", done_v, 1);

    // VERIFY_EN=0 instance
    @(negedge clk);
    data_n  = pack(8'h50);
    start_n = 1'b1;
    de = -1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (done_n) begin
        de = e;
        break;
      end
      @(negedge clk);
      start_n = 1'b0;
    end
    start_n = 1'b0;
    chk("nv_done_edge", de, 8);
    chk("nv_ren_cnt", ren_n, 0);
    chk("nv_wen_cnt", wen_n, T);
    chk("nv_mm", mm_n, 0);
    chk("nv_mem3", mem_n[15'(BASE + 3)], 8'h53);

    // Reset just after edge 4 of WRITE
    @(negedge clk);
    data_v  = pack(8'h40);
    start_v = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      start_v = 1'b0;
      @(posedge clk);
    end
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_en", bus_v.bram_en, 0);
    chk("mid_rst_wen", bus_v.bram_wen, 0);
    chk("mid_rst_busy", busy_v, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_done", done_v, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_written", bad_words_v(8'h40, 0, 3), 0);
    chk("mid_rst_untouched", bad_words_v(8'h10, 4, T-1), 0);

    run_v(8'h60, 1'b0, de);
    chk("post_rst_done_edge", de, 18);
    chk("post_rst_mm", mm_v, 0);
    chk("post_rst_mem", bad_words_v(8'h60, 0, T-1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/weight_writer_layer1.md
Name: weight_writer_layer1

Overview:
- Write-side counterpart of the layer-1 weight loaders.
- Takes a packed weight vector and serialises it into the shared weight BRAM, one W-bit word per cycle, starting at BASE_ADDR.
- Optionally reads the region back and compares every word against the captured vector.
- Used at bring-up and for reprogramming, before the loaders run. Its BRAM port signals match the loaders' BRAM interface.

Parameters:
- IN_SIZE, 256, inputs per neuron.
- OUT_SIZE, 8, neurons in the slice.
- W, 8, bits per weight.
- TOTAL_WEIGHTS, IN_SIZE*OUT_SIZE, words to write (T below).
- ADDR_WIDTH, 15, BRAM address width.
- BASE_ADDR, 12288, first BRAM address written.
- READ_LATENCY, 2, BRAM read latency in cycles (L below). Must be at least 1.
- VERIFY_EN, 1, when 1, run the readback/compare pass.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a write
- data_in  in  TOTAL_WEIGHTS*W  packed weights; word k is data_in[k*W +: W]
- bram_en  out  1  BRAM enable
- bram_ren  out  1  BRAM read enable
- bram_wen  out  1  BRAM write enable
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_din  out  W  BRAM write data
- bram_dout  in  W  BRAM read data, valid L cycles after the address is presented with ren=1
- busy  out  1  high from the start edge until done
- done  out  1  operation complete; held until the next start
- mismatch_count  out  ADDR_WIDTH+1  number of readback words that differed
- error  out  1  high when mismatch_count is non-zero; meaningful only while done=1

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0: bram_en, bram_ren, bram_wen, bram_addr, bram_din, busy, done, mismatch_count, error. Internal pointers cleared.
- Reset mid-operation: BRAM strobes drop at once. Already-written words stay in BRAM. No done is produced.
- All outputs are registered.
- States and transitions: IDLE -> WRITE -> (VERIFY -> DRAIN, if VERIFY_EN=1) -> DONE.
- IDLE / DONE:
  - On start=1, copy data_in into an internal shadow register; later data_in changes have no effect.
  - Clear done, mismatch_count, error and both pointers; set busy=1; enter WRITE.
- WRITE, edges 0..T-1 counted from the edge that sampled start:
  - Drive en=1, wen=1, ren=0, addr=BASE_ADDR+k, din=shadow word k.
  - After word T-1 is presented, go to VERIFY, or to DONE if VERIFY_EN=0.
- VERIFY, edges T..2T-1:
  - Drive en=1, ren=1, wen=0, addr=BASE_ADDR+k.
  - An L-deep valid/index shift register tracks each outstanding read.
  - The compare for read k samples bram_dout at edge T+k+L. On inequality with shadow word k, mismatch_count increments, saturating at T.
- DRAIN:
  - en=1, ren=0, wen=0; keep shifting until the last compare (edge 2T-1+L) completes.
- DONE:
  - en, ren and wen are 0; busy=0; done=1.
  - Timing with VERIFY_EN=1: done rises at edge 2T+L. With VERIFY_EN=0: done rises at edge T.
- start while busy=1: ignored, no effect on the operation in progress.
- start in DONE: identical to start in IDLE (restart).
- Addressing:
  - Addresses never wrap.
  - BASE_ADDR+T-1 must be below 2^ADDR_WIDTH; this is checked by a simulation assertion at time 0.
  - Pointers are ADDR_WIDTH+1 bits so that the value T is representable.

Test Plan:
- IN_SIZE=4, OUT_SIZE=2 (T=8), L=2, VERIFY_EN=1, data_in words 0x10..0x17 -> exactly 8 wen strobes at addresses 12288..12295 with din 0x10..0x17; 8 ren strobes at the same addresses; done at edge 18; mismatch_count=0; error=0.
- Same configuration, bench BRAM model corrupts address 12291 to 0xFF on readback -> mismatch_count=1, error=1, done at edge 18.
- VERIFY_EN=0, T=8 -> no ren strobe; done at edge 8; mismatch_count=0.
- data_in changed to all 0xAA one cycle after start -> BRAM still receives 0x10..0x17; start pulses during WRITE and VERIFY produce no extra strobes.
- rst asserted at edge 4 of WRITE -> en and wen fall immediately; busy=0; done stays 0; only addresses 12288..12291 hold written data. A subsequent start completes normally with done at edge 18.
- Back-to-back runs: a second start in DONE with new data 0x20..0x27 -> done drops, busy rises; writes 0x20..0x27; mismatch_count restarts from 0.
